// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

   typedef enum logic [1:0] {IDLE, REFILL, FILL} icache_state_t;

   localparam int ADDR_W = 64;
   localparam int WORD_W = 32;

   function automatic int ofs_bits(input int words_per_line);
      return $clog2(words_per_line);
   endfunction

   function automatic int idx_bits(input int lines);
      return $clog2(lines);
   endfunction

   // Byte offset bits [1:0] are never part of the tag or index.
   function automatic int tag_bits(input int lines, input int words_per_line);
      return ADDR_W - 2 - $clog2(lines) - $clog2(words_per_line);
   endfunction

endpackage

// File: rtl/icache_data_array.sv
// Cache line storage: one combinational read port and one synchronous write port.
module icache_data_array
   import icache_pkg::*;
#(
   parameter int LINES          = 64,
   parameter int WORDS_PER_LINE = 4,
   parameter int IDX_W          = idx_bits(LINES),
   parameter int OFS_W          = ofs_bits(WORDS_PER_LINE)
) (
   input  logic              CLK,
   input  logic [IDX_W-1:0]  rd_index,
   input  logic [OFS_W-1:0]  rd_offset,
   output logic [WORD_W-1:0] rd_data,
   input  logic [IDX_W-1:0]  wr_index,
   input  logic [OFS_W-1:0]  wr_beat,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              we
);

   logic [WORD_W-1:0] words [LINES*WORDS_PER_LINE];

   assign rd_data = words[{rd_index, rd_offset}];

   always_ff @(posedge CLK) begin
      if (we) begin
         words[{wr_index, wr_beat}] <= wr_data;
      end
   end

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped icache with combinational hit path and a line-refill FSM.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
//
// state  | meaning
// IDLE   | answer lookups; a miss latches the line base and starts a refill
// REFILL | one beat request per word, mem_addr held until each ack
// FILL   | install tag and valid bit for the latched line
module icache_responder
   import icache_pkg::*;
#(
   parameter int LINES          = 64,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [63:0] PC,
   input  logic        fence_i,
   output logic        icache_r,
   output logic [31:0] instruction,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int OFS    = ofs_bits(WORDS_PER_LINE);
   localparam int IDX    = idx_bits(LINES);
   localparam int TAG    = tag_bits(LINES, WORDS_PER_LINE);
   localparam int IDX_LO = OFS + 2;
   localparam int TAG_LO = OFS + 2 + IDX;
   localparam logic [OFS-1:0] LAST_BEAT = OFS'(WORDS_PER_LINE - 1);

   icache_state_t  state;
   logic [OFS-1:0] beat;
   logic [LINES-1:0] valid;
   logic [TAG-1:0] tags [LINES];
   logic           flush_pending;

   logic [OFS-1:0] pc_offset;
   logic [IDX-1:0] pc_index;
   logic [TAG-1:0] pc_tag;
   logic [IDX-1:0] fill_index;
   logic [TAG-1:0] fill_tag;
   logic [31:0]    rd_data;
   logic           hit;
   logic           beat_we;
   logic           unused_pc_bits;

   assign pc_offset      = PC[OFS+1:2];
   assign pc_index       = PC[TAG_LO-1:IDX_LO];
   assign pc_tag         = PC[63:TAG_LO];
   assign unused_pc_bits = ^PC[1:0];

   // The line base never changes during a refill, so mem_addr carries the fill index and tag.
   assign fill_index = mem_addr[TAG_LO-1:IDX_LO];
   assign fill_tag   = mem_addr[63:TAG_LO];

   assign hit         = (state == IDLE) && valid[pc_index] && (tags[pc_index] == pc_tag);
   assign icache_r    = hit;
   assign instruction = hit ? rd_data : 32'd0;
   assign beat_we     = (state == REFILL) && mem_req && mem_ack;

   icache_data_array #(
      .LINES          (LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE)
   ) u_data (
      .CLK       (CLK),
      .rd_index  (pc_index),
      .rd_offset (pc_offset),
      .rd_data   (rd_data),
      .wr_index  (fill_index),
      .wr_beat   (beat),
      .wr_data   (mem_rdata),
      .we        (beat_we)
   );

   always_ff @(posedge CLK) begin
      if (state == FILL) begin
         tags[fill_index] <= fill_tag;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state         <= IDLE;
         valid         <= '0;
         beat          <= '0;
         flush_pending <= 1'b0;
         mem_req       <= 1'b0;
         mem_addr      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fence_i) begin
                  valid <= '0;
               end
               if (!hit) begin
                  mem_addr <= {PC[63:IDX_LO], {IDX_LO{1'b0}}};
                  beat     <= '0;
                  mem_req  <= 1'b1;
                  state    <= REFILL;
               end
            end
            REFILL: begin
               if (fence_i) begin
                  flush_pending <= 1'b1;
               end
               if (mem_ack) begin
                  if (beat == LAST_BEAT) begin
                     mem_req <= 1'b0;
                     state   <= FILL;
                  end else begin
                     beat     <= beat + OFS'(1);
                     mem_addr <= mem_addr + 64'd4;
                  end
               end
            end
            FILL: begin
               valid[fill_index] <= 1'b1;
               // A fence seen during the refill also drops the line just installed.
               if (fence_i || flush_pending) begin
                  valid <= '0;
               end
               flush_pending <= 1'b0;
               state         <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         hit_count  <= 32'd0;
         miss_count <= 32'd0;
      end else begin
         if (hit) begin
            hit_count <= hit_count + 32'd1;
         end
         if ((state == IDLE) && !hit) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder with a behavioural instruction-memory responder.
module tb_icache_responder;

   logic        CLK;
   logic        RESET;
   logic [63:0] PC;
   logic        fence_i;
   logic        icache_r;
   logic [31:0] instruction;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ack;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int checks = 0;
   int errors = 0;

   int          ack_delay = 0;
   int          wait_cnt  = 0;
   int          hold_viol = 0;
   logic        waiting   = 1'b0;
   logic        spurious  = 1'b0;
   logic [63:0] held_addr = 64'd0;
   logic [63:0] ack_addrs [$];

   icache_responder dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .PC          (PC),
      .fence_i     (fence_i),
      .icache_r    (icache_r),
      .instruction (instruction),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack)
`ifdef ICACHE_PERF_CNT_EN
      ,
      .hit_count   (hit_count),
      .miss_count  (miss_count)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] word_of(input logic [63:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   // Memory side: acks after ack_delay wait cycles, logs accepted addresses.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 32'd0;
      forever begin
         @(negedge CLK);
         if (mem_req === 1'b1) begin
            if (waiting && (mem_addr !== held_addr)) hold_viol++;
            held_addr = mem_addr;
            if (wait_cnt >= ack_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = word_of(mem_addr);
               ack_addrs.push_back(mem_addr);
               wait_cnt  = 0;
               waiting   = 1'b0;
            end else begin
               mem_ack   = 1'b0;
               mem_rdata = 32'h0BAD_0BAD;
               wait_cnt++;
               waiting   = 1'b1;
            end
         end else begin
            mem_ack   = spurious;
            mem_rdata = 32'hDEAD_BEEF;
            wait_cnt  = 0;
            waiting   = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
   endtask

   // Presents pc on cycle 0 (must miss), then follows the refill until the hit appears.
   task automatic miss_refill(input logic [63:0] pc, input int delay, input int exp_cyc,
                              input string nm);
      logic [63:0] base;
      int n;
      logic addr_ok;
      base = {pc[63:4], 4'h0};
      ack_delay = delay;
      ack_addrs.delete();
      hold_viol = 0;
      PC = pc;
      #1;
      checks++;
      if (icache_r !== 1'b0) begin
         errors++;
         $display("FAIL %s_miss_c0: icache_r=%b expected 0", nm, icache_r);
      end
      checks++;
      if (mem_req !== 1'b0) begin
         errors++;
         $display("FAIL %s_req_c0: mem_req=%b expected 0", nm, mem_req);
      end
      n = 0;
      while ((icache_r !== 1'b1) && (n < 60)) begin
         tick();
         n++;
         if (n == 1) begin
            checks++;
            if ((mem_req !== 1'b1) || (mem_addr !== base)) begin
               errors++;
               $display("FAIL %s_req_c1: mem_req=%b mem_addr=%0h expected 1/%0h",
                        nm, mem_req, mem_addr, base);
            end
         end
      end
      checks++;
      if (n != exp_cyc) begin
         errors++;
         $display("FAIL %s_hit_cycle: hit on cycle %0d expected %0d", nm, n, exp_cyc);
      end
      addr_ok = (ack_addrs.size() == 4);
      if (addr_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (ack_addrs[i] !== base + 64'(4 * i)) addr_ok = 1'b0;
         end
      end
      checks++;
      if (!addr_ok) begin
         errors++;
         $display("FAIL %s_beat_addrs: %0d beats acked, expected 4 from %0h",
                  nm, ack_addrs.size(), base);
      end
      checks++;
      if (hold_viol != 0) begin
         errors++;
         $display("FAIL %s_addr_hold: %0d changes during wait, expected 0", nm, hold_viol);
      end
      checks++;
      if (instruction !== word_of({pc[63:2], 2'b00})) begin
         errors++;
         $display("FAIL %s_data: instruction=%0h expected %0h",
                  nm, instruction, word_of({pc[63:2], 2'b00}));
      end
   endtask

   task automatic test_reset();
      RESET   = 1'b1;
      PC      = 64'd0;
      fence_i = 1'b0;
      tick();
      checks++;
      if ((icache_r !== 1'b0) || (instruction !== 32'd0)) begin
         errors++;
         $display("FAIL reset_outputs: icache_r=%b instruction=%0h expected 0/0", icache_r, instruction);
      end
      checks++;
      if ((mem_req !== 1'b0) || (mem_addr !== 64'd0)) begin
         errors++;
         $display("FAIL reset_mem: mem_req=%b mem_addr=%0h expected 0/0", mem_req, mem_addr);
      end
`ifdef ICACHE_PERF_CNT_EN
      checks++;
      if ((hit_count !== 32'd0) || (miss_count !== 32'd0)) begin
         errors++;
         $display("FAIL reset_counters: hit=%0d miss=%0d expected 0/0", hit_count, miss_count);
      end
`endif
      tick();
      RESET = 1'b0;
   endtask

   task automatic test_basic_refill();
      miss_refill(64'h0, 0, 6, "basic");
      PC = 64'h8;
      #1;
      checks++;
      if ((icache_r !== 1'b1) || (instruction !== word_of(64'h8))) begin
         errors++;
         $display("FAIL basic_word2: icache_r=%b instruction=%0h expected 1/%0h",
                  icache_r, instruction, word_of(64'h8));
      end
   endtask

   task automatic test_conflict();
      miss_refill(64'h400, 0, 6, "conflict");
      PC = 64'h404;
      #1;
      checks++;
      if ((icache_r !== 1'b1) || (instruction !== word_of(64'h404))) begin
         errors++;
         $display("FAIL conflict_word1: icache_r=%b instruction=%0h expected 1/%0h",
                  icache_r, instruction, word_of(64'h404));
      end
      PC = 64'h0;
      #1;
      checks++;
      if (icache_r !== 1'b0) begin
         errors++;
         $display("FAIL conflict_evict: icache_r=%b expected 0", icache_r);
      end
      miss_refill(64'h0, 0, 6, "refetch");
   endtask

   task automatic test_ack_delay();
      miss_refill(64'h50, 3, 18, "delay");
      ack_delay = 0;
      spurious  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ((mem_req !== 1'b0) || (mem_addr !== 64'h5C) || (icache_r !== 1'b1) ||
             (instruction !== word_of(64'h50))) begin
            errors++;
            $display("FAIL spurious_ack: req=%b addr=%0h r=%b instr=%0h expected 0/5c/1/%0h",
                     mem_req, mem_addr, icache_r, instruction, word_of(64'h50));
         end
      end
      spurious = 1'b0;
   endtask

   task automatic test_fence();
      do_reset();
      PC = 64'h100;
      #1;
      tick();
      tick();
      fence_i = 1'b1;
      tick();
      fence_i = 1'b0;
      tick();
      tick();
      checks++;
      if ((mem_req !== 1'b0) || (icache_r !== 1'b0)) begin
         errors++;
         $display("FAIL fence_fill_cycle: mem_req=%b icache_r=%b expected 0/0", mem_req, icache_r);
      end
      tick();
      checks++;
      if (icache_r !== 1'b0) begin
         errors++;
         $display("FAIL fence_refill_flush: icache_r=%b expected 0", icache_r);
      end
      miss_refill(64'h100, 0, 6, "fence_again");
`ifdef ICACHE_PERF_CNT_EN
      checks++;
      if ((miss_count !== 32'd2) || (hit_count !== 32'd0)) begin
         errors++;
         $display("FAIL fence_counters: miss=%0d hit=%0d expected 2/0", miss_count, hit_count);
      end
      tick();
      checks++;
      if (hit_count !== 32'd1) begin
         errors++;
         $display("FAIL hit_count_inc: hit=%0d expected 1", hit_count);
      end
`endif
      fence_i = 1'b1;
      #1;
      checks++;
      if (icache_r !== 1'b1) begin
         errors++;
         $display("FAIL fence_idle_same_cycle: icache_r=%b expected 1", icache_r);
      end
      tick();
      fence_i = 1'b0;
      #1;
      checks++;
      if (icache_r !== 1'b0) begin
         errors++;
         $display("FAIL fence_idle_next: icache_r=%b expected 0", icache_r);
      end
   endtask

   task automatic test_reset_mid_refill();
      do_reset();
      PC = 64'h60;
      #1;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if ((mem_req !== 1'b1) || (mem_addr !== 64'h6C)) begin
         errors++;
         $display("FAIL midrst_beat3: mem_req=%b mem_addr=%0h expected 1/6c", mem_req, mem_addr);
      end
      RESET = 1'b1;
      #1;
      checks++;
      if ((mem_req !== 1'b0) || (mem_addr !== 64'd0) || (icache_r !== 1'b0)) begin
         errors++;
         $display("FAIL midrst_async: req=%b addr=%0h r=%b expected 0/0/0",
                  mem_req, mem_addr, icache_r);
      end
      tick();
      tick();
      RESET = 1'b0;
      miss_refill(64'h64, 0, 6, "after_rst");
   endtask

   task automatic test_back_to_back();
      logic ok;
      do_reset();
      ack_addrs.delete();
      PC = 64'h200;
      #1;
      tick();
      checks++;
      if (mem_addr !== 64'h200) begin
         errors++;
         $display("FAIL switch_first_addr: mem_addr=%0h expected 200", mem_addr);
      end
      tick();
      PC = 64'h300;
      for (int i = 0; i < 4; i++) tick();
      ok = (ack_addrs.size() == 4);
      if (ok) begin
         for (int i = 0; i < 4; i++) begin
            if (ack_addrs[i] !== 64'h200 + 64'(4 * i)) ok = 1'b0;
         end
      end
      checks++;
      if (!ok || (icache_r !== 1'b0) || (mem_req !== 1'b0)) begin
         errors++;
         $display("FAIL switch_first_line: beats=%0d r=%b req=%b expected 4 beats of 200/0/0",
                  ack_addrs.size(), icache_r, mem_req);
      end
      miss_refill(64'h300, 0, 6, "switch_second");
      PC = 64'h200;
      #1;
      checks++;
      if ((icache_r !== 1'b1) || (instruction !== word_of(64'h200))) begin
         errors++;
         $display("FAIL switch_hit_200: r=%b instr=%0h expected 1/%0h",
                  icache_r, instruction, word_of(64'h200));
      end
      PC = 64'h30C;
      #1;
      checks++;
      if ((icache_r !== 1'b1) || (instruction !== word_of(64'h30C))) begin
         errors++;
         $display("FAIL switch_hit_30c: r=%b instr=%0h expected 1/%0h",
                  icache_r, instruction, word_of(64'h30C));
      end
   endtask

   initial begin
      test_reset();
      test_basic_refill();
      test_conflict();
      test_ack_delay();
      test_fence();
      test_reset_mid_refill();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/icache_responder.md
# icache_responder

Direct-mapped instruction cache answering the fetch stage's PC lookups, with a miss-refill state machine that reads whole lines from the instruction memory port over a req/ack handshake. It sits between fetch, which drives `PC` and samples `icache_r`/`instruction` every cycle, and the memory arbiter. Hits are answered combinationally in the same cycle. Misses stall fetch, through `icache_r` low, until the line is installed.

## Interface
Parameters:
- `LINES`, default 64: number of cache lines; must be a power of 2.
- `WORDS_PER_LINE`, default 4: 32-bit words per line; must be a power of 2 and ≥2.

Ports:
- `CLK`  in  1  clock. Single clock domain.
- `RESET`  in  1  asynchronous, active-high reset.
- `PC`  in  64  fetch address.
- `fence_i`  in  1  one-cycle pulse; invalidate all lines.
- `icache_r`  out  1  a hit is present; `instruction` is valid.
- `instruction`  out  32  instruction word at `PC`. Drives 0 when `icache_r`=0.
- `mem_req`  out  1  refill beat request.
- `mem_addr`  out  64  word-aligned beat address.
- `mem_rdata`  in  32  beat data, valid with `mem_ack`.
- `mem_ack`  in  1  beat accepted and data returned.
- `hit_count`, `miss_count`  out  32 each  present only with `ICACHE_PERF_CNT_EN`.

## Operation
- Address split:
  - offset = `PC[OFS+1:2]`, where OFS = log2(`WORDS_PER_LINE`).
  - index = next log2(`LINES`) bits.
  - tag = all remaining upper bits.
  - `PC[1:0]` is ignored; fetch flags misalignment itself.
- Hit: state IDLE, line valid, tag match. Then `icache_r`=1 and `instruction` = data[index][offset].
- States:
  - IDLE: on a miss, latch line base = {`PC[63:OFS+2]`, 0}, set beat=0, go to REFILL.
  - REFILL: `mem_req`=1 with `mem_addr` = base + 4·beat held stable until `mem_ack`. Each ack writes `mem_rdata` into data[index][beat] and increments beat. The ack on beat `WORDS_PER_LINE`-1 goes to FILL.
  - FILL: write tag and set valid for the latched index, then go to IDLE.
- `icache_r`=0 in REFILL and FILL, regardless of `PC`.
- A `PC` change during REFILL does not abort the refill. The latched line completes, then the new `PC` is looked up in IDLE; a second miss starts a new refill.
- `fence_i`:
  - In IDLE: clears all valid bits at the next edge. `icache_r` is 0 on the cycle after the pulse.
  - In REFILL/FILL: sets a pending flag. On the FILL→IDLE edge, all valid bits are cleared, including the newly filled line, and the flag is cleared.
- `mem_ack` while `mem_req`=0 is ignored.
- Asynchronous RESET:
  - state IDLE, all valid bits 0, beat 0, pending-flush flag 0, `mem_req` 0, `mem_addr` 0.
  - `icache_r` 0, `instruction` 0, counters 0.
  - Data array contents are not reset.
  - Assertion mid-refill abandons the refill; no partial line is marked valid.

## Timing
- Hit latency is 0 cycles; the result is combinational from `PC`.
- Miss timeline:
  - The miss is seen in IDLE on cycle 0.
  - `mem_req` is registered and rises on cycle 1.
  - With ack in the same cycle as req, beats complete on cycles 1…W.
  - FILL occurs on cycle W+1; `mem_req` falls there.
  - A hit is visible on cycle W+2.
  - Minimum miss penalty is W+2 cycles; each ack wait state adds one cycle.
- `mem_addr` changes only on the edge following an ack.

## Configuration
`ICACHE_PERF_CNT_EN`:
- Defined:
  - `hit_count` increments every IDLE cycle with a hit.
  - `miss_count` increments once per IDLE→REFILL transition.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both ports and both counters are absent; no other behaviour changes.

## Structure
- Package `icache_pkg`:
  - `icache_state_t` enum {IDLE, REFILL, FILL}.
  - Functions/constants for offset, index and tag widths derived from the parameters.
- Sub-module `icache_data_array`: LINES×WORDS_PER_LINE×32 storage with one combinational read port (index, offset) and one synchronous write port (index, beat, data, we). Tags and valid bits stay in the top level.

## Test plan
- Reset, then `PC`=0x0 → `icache_r`=0 and `mem_req`=1 on cycle 1 with `mem_addr`=0x0, 0x4, 0x8, 0xC on successive acks. Hit on cycle 6 with `instruction` = beat word 0; `PC`=0x8 then returns beat 2 in the same cycle.
- `PC`=0x400 with LINES=64 and W=4 (same index as 0x0, different tag) → miss and refill from 0x400. Afterwards `PC`=0x0 misses again.
- Ack delayed 3 cycles per beat → `mem_addr` holds stable during each wait. Hit appears on cycle 18; a spurious `mem_ack` while `mem_req`=0 changes nothing.
- `fence_i` pulsed mid-refill of 0x100 → refill completes, then `icache_r`=0. `PC`=0x100 misses again and `miss_count`=2 (with `ICACHE_PERF_CNT_EN`).
- RESET asserted asynchronously after beat 2 of a refill → `mem_req`=0 immediately. After release, `PC` of the same line misses and refills all 4 beats.
- `PC` switched from 0x200 to 0x300 during the refill of 0x200 → refill of 0x200 finishes, then 0x300 refills. Afterwards both addresses hit.
